cnt_core: RTL and testbench

CNT_CORE -- requirements
Module: cnt_core

---
 rtl/cnt_core.sv | 52 +++++
 tb/tb_cnt_core.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cnt_core.sv
// cnt_core: up/down counter with parallel load, wrap pulses and saturating wrap count
module cnt_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic             updown,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data,
    output logic             carry,
    output logic             borrow,
    output logic             at_zero,
    output logic             at_max,
    output logic [WIDTH-1:0] wrap_cnt,
    output logic             wrap_sat
);
    localparam logic [WIDTH-1:0] MAX = '1;
    logic             up_wrap;
    logic             dn_wrap;
    logic             wrap;
    logic [WIDTH-1:0] next_cnt;
    // next counter value and wrap detection; a load never counts as a wrap
    always_comb begin
        up_wrap  = !load && en && updown && (out_data == MAX);
        dn_wrap  = !load && en && !updown && (out_data == '0);
        wrap     = up_wrap || dn_wrap;
        next_cnt = load ? in_data
                 : en ? (updown ? out_data + WIDTH'(1) : out_data - WIDTH'(1))
                 : out_data;
    end
    // counter, wrap pulses and saturating wrap statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            wrap_cnt <= '0;
            wrap_sat <= 1'b0;
        end else begin
            out_data <= next_cnt;
            carry    <= up_wrap;
            borrow   <= dn_wrap;
            if (wrap && wrap_cnt != MAX)
                wrap_cnt <= wrap_cnt + WIDTH'(1);
            wrap_sat <= wrap_sat || (wrap && wrap_cnt == MAX - WIDTH'(1));
        end
    end
    assign at_zero = (out_data == '0);
    assign at_max  = (out_data == MAX);
endmodule

// File: tb/tb_cnt_core.sv
// tb_cnt_core: directed self-checking bench for cnt_core
module tb_cnt_core;
    logic       clk = 1'b0;
    logic       rst_n, en, load, updown;
    logic [7:0] in_data;
    logic [7:0] out_data, wrap_cnt;
    logic       carry, borrow, at_zero, at_max, wrap_sat;
    int         errors = 0;
    int         checks = 0;

    cnt_core #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .updown(updown),
        .in_data(in_data), .out_data(out_data), .carry(carry), .borrow(borrow),
        .at_zero(at_zero), .at_max(at_max), .wrap_cnt(wrap_cnt), .wrap_sat(wrap_sat)
    );

    always #5 clk = ~clk;

    // advance one edge; inputs change and outputs are sampled 4ns later
    task automatic tick();
        @(posedge clk);
        #4;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] d, input logic c, input logic b,
                           input logic [7:0] w, input logic s);
        chk({tag, ".out_data"}, out_data, d);
        chk({tag, ".carry"}, {7'd0, carry}, {7'd0, c});
        chk({tag, ".borrow"}, {7'd0, borrow}, {7'd0, b});
        chk({tag, ".at_zero"}, {7'd0, at_zero}, {7'd0, d == 8'h00});
        chk({tag, ".at_max"}, {7'd0, at_max}, {7'd0, d == 8'hFF});
        chk({tag, ".wrap_cnt"}, wrap_cnt, w);
        chk({tag, ".wrap_sat"}, {7'd0, wrap_sat}, {7'd0, s});
    endtask

    initial begin
        logic [7:0] exp_w;
        logic       up;
        rst_n = 1'b0; load = 1'b1; in_data = 8'hA5; en = 1'b1; updown = 1'b1;
        tick(); tick();
        chk_all("reset", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        rst_n = 1'b1; load = 1'b1; in_data = 8'hFE;
        tick();
        chk_all("load_fe", 8'hFE, 1'b0, 1'b0, 8'h00, 1'b0);
        load = 1'b0; en = 1'b1; updown = 1'b1;
        tick();
        chk_all("up_ff", 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk_all("up_00", 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);
        tick();
        chk_all("up_01", 8'h01, 1'b0, 1'b0, 8'h01, 1'b0);

        load = 1'b1; in_data = 8'h01;
        tick();
        chk_all("load_01", 8'h01, 1'b0, 1'b0, 8'h01, 1'b0);
        load = 1'b0; updown = 1'b0;
        tick();
        chk_all("dn_00", 8'h00, 1'b0, 1'b0, 8'h01, 1'b0);
        tick();
        chk_all("dn_ff", 8'hFF, 1'b0, 1'b1, 8'h02, 1'b0);
        tick();
        chk_all("dn_fe", 8'hFE, 1'b0, 1'b0, 8'h02, 1'b0);

        load = 1'b1; in_data = 8'h10;
        tick();
        chk_all("load_10", 8'h10, 1'b0, 1'b0, 8'h02, 1'b0);
        in_data = 8'h80; en = 1'b1; updown = 1'b1;
        tick();
        chk_all("load_prio", 8'h80, 1'b0, 1'b0, 8'h02, 1'b0);
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("hold_80", 8'h80, 1'b0, 1'b0, 8'h02, 1'b0);
        end

        load = 1'b1; in_data = 8'hFF;
        tick();
        chk_all("load_ff", 8'hFF, 1'b0, 1'b0, 8'h02, 1'b0);
        in_data = 8'h00; en = 1'b1; updown = 1'b1;
        tick();
        chk_all("load_ff_to_00", 8'h00, 1'b0, 1'b0, 8'h02, 1'b0);
        in_data = 8'hFF; updown = 1'b0;
        tick();
        chk_all("load_00_to_ff", 8'hFF, 1'b0, 1'b0, 8'h02, 1'b0);

        load = 1'b0; en = 1'b1;
        exp_w = 8'h02;
        for (int i = 0; i < 300; i++) begin
            up = (i % 2 == 0);
            updown = up;
            tick();
            if (exp_w != 8'hFF) exp_w = exp_w + 8'h01;
            chk_all("toggle", up ? 8'h00 : 8'hFF, up, !up, exp_w, exp_w == 8'hFF);
        end
        load = 1'b1; in_data = 8'h12; en = 1'b0;
        tick();
        chk_all("load_after_sat", 8'h12, 1'b0, 1'b0, 8'hFF, 1'b1);

        in_data = 8'h30;
        tick();
        load = 1'b0; en = 1'b1; updown = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk_all("count_37", 8'h37, 1'b0, 1'b0, 8'hFF, 1'b1);
        rst_n = 1'b0;
        tick();
        chk_all("mid_reset", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_all("resume", 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);

        load = 1'b1; in_data = 8'hFF;
        tick();
        load = 1'b0; rst_n = 1'b0;
        tick();
        chk_all("reset_at_wrap", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1; en = 1'b0;
        tick();
        chk_all("no_pending", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
